// File: rtl/cla_adder_16b.sv
// cla_adder_16b: 16-bit carry-lookahead ALU slice with a registered status word.
//   Builds AND, OR, ADD and SUB from a two-level carry-lookahead adder
//   (four 4-bit groups plus a group-carry lookahead unit).
//   Optional feature: define CLA_ADDER_16B_SLT_EN to enable op 3'b111 (set-less-than).
// Ports:
//   clk       - rising-edge clock, used only by the status register
//   reset_n   - asynchronous active-low reset of the status register
//   a, b      - 16-bit operands
//   op        - 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (optional), others reserved
//   flags_we  - status register load enable
//   r         - result (combinational)
//   c_out     - carry out of bit 15 (combinational)
//   overflow  - signed overflow (combinational)
//   zero      - r == 0 (combinational)
//   flags_q   - registered {negative, zero, overflow, c_out}
module cla_adder_16b (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [2:0]  op,
    input  logic        flags_we,
    output logic [15:0] r,
    output logic        c_out,
    output logic        overflow,
    output logic        zero,
    output logic [3:0]  flags_q
);

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned GROUP_W = 4;
    localparam int unsigned N_GROUP = WIDTH / GROUP_W;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
`ifdef CLA_ADDER_16B_SLT_EN
    localparam logic [2:0] OP_SLT = 3'b111;
`endif

    logic               sub_mode;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH-1:0]   g;
    logic [WIDTH-1:0]   p;
    logic [N_GROUP-1:0] grp_g;
    logic [N_GROUP-1:0] grp_p;
    logic [N_GROUP:0]   grp_c;
    logic [WIDTH:0]     c;
    logic [WIDTH-1:0]   sum;
    logic               add_ovf;
    logic [3:0]         flags_d;

    // Subtract (and SLT) invert b and inject carry-in 1.
`ifdef CLA_ADDER_16B_SLT_EN
    assign sub_mode = (op == OP_SUB) || (op == OP_SLT);
`else
    assign sub_mode = (op == OP_SUB);
`endif

    assign b_eff = sub_mode ? ~b : b;
    assign g     = a & b_eff;
    assign p     = a ^ b_eff;

    // Group generate / propagate for each 4-bit group.
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int k = 0; k < int'(N_GROUP); k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
        end
    end

    // Second-level lookahead: every group carry comes straight from carry-in.
    always_comb begin
        grp_c    = '0;
        grp_c[0] = sub_mode;
        grp_c[1] = grp_g[0] | (grp_p[0] & sub_mode);
        grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0])
                 | (grp_p[1] & grp_p[0] & sub_mode);
        grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1])
                 | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & sub_mode);
        grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2])
                 | (grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & sub_mode);
    end

    // Bit carries inside each group, looked ahead from that group's carry-in.
    always_comb begin
        c        = '0;
        c[WIDTH] = grp_c[N_GROUP];
        for (int k = 0; k < int'(N_GROUP); k++) begin
            c[4*k]   = grp_c[k];
            c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & grp_c[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
        end
    end

    assign sum     = p ^ c[WIDTH-1:0];
    assign add_ovf = c[WIDTH-1] ^ c[WIDTH];

    // Result and flag selection.
    always_comb begin
        r        = '0;
        c_out    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_ADD, OP_SUB: begin
                r        = sum;
                c_out    = c[WIDTH];
                overflow = add_ovf;
            end
`ifdef CLA_ADDER_16B_SLT_EN
            OP_SLT: begin
                // Signed less-than: true sign of a-b is sum sign corrected by overflow.
                r        = {15'b0, sum[WIDTH-1] ^ add_ovf};
                c_out    = c[WIDTH];
                overflow = add_ovf;
            end
`endif
            default: begin
                r        = '0;
                c_out    = 1'b0;
                overflow = 1'b0;
            end
        endcase
    end

    assign zero = (r == 16'h0000);

    // Status register next state.
    always_comb begin
        flags_d = flags_q;
        if (flags_we) begin
            flags_d = {r[WIDTH-1], zero, overflow, c_out};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_cla_adder_16b.sv
// tb_cla_adder_16b: directed-vector bench for cla_adder_16b.
//   Checks combinational ALU results/flags and the status register behaviour.
//   Honours CLA_ADDER_16B_SLT_EN for the op 3'b111 expectations.
module tb_cla_adder_16b;

    logic        clk;
    logic        reset_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        flags_we;
    logic [15:0] r;
    logic        c_out;
    logic        overflow;
    logic        zero;
    logic [3:0]  flags_q;

    int unsigned n_chk;
    int unsigned n_bad;

    cla_adder_16b dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .a        (a),
        .b        (b),
        .op       (op),
        .flags_we (flags_we),
        .r        (r),
        .c_out    (c_out),
        .overflow (overflow),
        .zero     (zero),
        .flags_q  (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp_v);
        end
    endtask

    // Apply one vector between clock edges and check all combinational outputs.
    task automatic run_vec(input string tag, input logic [2:0] v_op,
                           input logic [15:0] v_a, input logic [15:0] v_b,
                           input logic [15:0] e_r, input logic e_c,
                           input logic e_v, input logic e_z);
        @(negedge clk);
        op = v_op;
        a  = v_a;
        b  = v_b;
        #1;
        chk({tag, ".r"}, r, e_r);
        chk({tag, ".c"}, 16'(c_out), 16'(e_c));
        chk({tag, ".v"}, 16'(overflow), 16'(e_v));
        chk({tag, ".z"}, 16'(zero), 16'(e_z));
    endtask

    initial begin
        n_chk    = 0;
        n_bad    = 0;
        reset_n  = 1'b0;
        flags_we = 1'b0;
        op       = 3'b010;
        a        = 16'd1;
        b        = 16'd2;
        #1;
        chk("rst_flags", 16'(flags_q), 16'h0000);
        chk("rst_comb_r", r, 16'd3);

        // Load flags from 30000 + 30000.
        @(negedge clk);
        reset_n  = 1'b1;
        op       = 3'b010;
        a        = 16'd30000;
        b        = 16'd30000;
        flags_we = 1'b1;
        @(posedge clk);
        #1;
        chk("flags_load", 16'(flags_q), 16'h000A);

        // Hold with write enable low.
        @(negedge clk);
        flags_we = 1'b0;
        a        = 16'd1;
        b        = 16'd2;
        @(posedge clk);
        #1;
        chk("flags_hold", 16'(flags_q), 16'h000A);

        // Load flags from 5 - 5.
        @(negedge clk);
        flags_we = 1'b1;
        op       = 3'b110;
        a        = 16'd5;
        b        = 16'd5;
        @(posedge clk);
        #1;
        chk("flags_sub", 16'(flags_q), 16'h0005);

        // Mid-cycle asynchronous reset.
        @(negedge clk);
        flags_we = 1'b0;
        op       = 3'b010;
        a        = 16'd1;
        b        = 16'd2;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("flags_async_rst", 16'(flags_q), 16'h0000);
        chk("comb_in_rst", r, 16'd3);
        @(negedge clk);
        reset_n = 1'b1;

        // ADD
        run_vec("add_1_2",    3'b010, 16'd1,     16'd2,     16'd3,     1'b0, 1'b0, 1'b0);
        run_vec("add_20000",  3'b010, 16'd20000, 16'd14,    16'd20014, 1'b0, 1'b0, 1'b0);
        run_vec("add_12356",  3'b010, 16'd12356, 16'd14500, 16'd26856, 1'b0, 1'b0, 1'b0);
        run_vec("add_pos_ov", 3'b010, 16'd30000, 16'd30000, 16'hEA60,  1'b0, 1'b1, 1'b0);
        run_vec("add_neg_ov", 3'b010, 16'h8AD0,  16'h8AD0,  16'h15A0,  1'b1, 1'b1, 1'b0);
        run_vec("add_wrap",   3'b010, 16'hFFFF,  16'h0001,  16'h0000,  1'b1, 1'b0, 1'b1);
        // AND / OR
        run_vec("and_8888",   3'b000, 16'h8888,  16'h8889,  16'h8888,  1'b0, 1'b0, 1'b0);
        run_vec("and_zero",   3'b000, 16'hFFFF,  16'h0000,  16'h0000,  1'b0, 1'b0, 1'b1);
        run_vec("or_aaaa",    3'b001, 16'hAAAA,  16'h5555,  16'hFFFF,  1'b0, 1'b0, 1'b0);
        run_vec("or_f0f0",    3'b001, 16'hF0F0,  16'hF0F1,  16'hF0F1,  1'b0, 1'b0, 1'b0);
        // SUB
        run_vec("sub_8_4",    3'b110, 16'd8,     16'd4,     16'd4,     1'b1, 1'b0, 1'b0);
        run_vec("sub_20000",  3'b110, 16'd20000, 16'd13000, 16'd7000,  1'b1, 1'b0, 1'b0);
        run_vec("sub_5_5",    3'b110, 16'd5,     16'd5,     16'h0000,  1'b1, 1'b0, 1'b1);
        run_vec("sub_borrow", 3'b110, 16'd0,     16'd1,     16'hFFFF,  1'b0, 1'b0, 1'b0);
        run_vec("sub_ov",     3'b110, 16'h8000,  16'h0001,  16'h7FFF,  1'b1, 1'b1, 1'b0);
        // Reserved codes
        run_vec("rsv_011",    3'b011, 16'd5,     16'd3,     16'h0000,  1'b0, 1'b0, 1'b1);
        run_vec("rsv_100",    3'b100, 16'hFFFF,  16'hFFFF,  16'h0000,  1'b0, 1'b0, 1'b1);
        run_vec("rsv_101",    3'b101, 16'h1234,  16'h8765,  16'h0000,  1'b0, 1'b0, 1'b1);
`ifdef CLA_ADDER_16B_SLT_EN
        run_vec("slt_lt",     3'b111, 16'hFFFD,  16'h0002,  16'h0001,  1'b1, 1'b0, 1'b0);
        run_vec("slt_ge",     3'b111, 16'h0002,  16'hFFFD,  16'h0000,  1'b0, 1'b0, 1'b1);
        run_vec("slt_ov",     3'b111, 16'h8000,  16'h0001,  16'h0001,  1'b1, 1'b1, 1'b0);
`else
        run_vec("op111_rsv_a", 3'b111, 16'hFFFD, 16'h0002,  16'h0000,  1'b0, 1'b0, 1'b1);
        run_vec("op111_rsv_b", 3'b111, 16'h0002, 16'hFFFD,  16'h0000,  1'b0, 1'b0, 1'b1);
`endif

        // Flags register must not have moved during the combinational sweep.
        #1;
        chk("flags_idle", 16'(flags_q), 16'h0000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
